// File: rtl/mc_core_pkg.sv
// Shared types and encodings for the mc_core multicycle RV datapath.
package mc_core_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MREQ, S_MWAIT, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] EBREAK_WORD = 32'h00100073;

endpackage

// File: rtl/regfile_param.sv
// Architectural register file: two operand reads, one debug read, one write.
// Indices wrap modulo NREGS; entry 0 is never written so it always reads zero.
module regfile_param #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  input  logic [4:0]      rad_i,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  output logic [XLEN-1:0] rdd_o
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i[AW-1:0] != '0)) begin
      regs_q[wa_i[AW-1:0]] <= wd_i;
    end
  end

  assign rd1_o = regs_q[ra1_i[AW-1:0]];
  assign rd2_o = regs_q[ra2_i[AW-1:0]];
  assign rdd_o = regs_q[rad_i[AW-1:0]];

endmodule

// File: rtl/mc_core.sv
// Self-sequencing multicycle RV core with handshaked instruction/data ports.
// FETCH req | FWAIT ir<-rdata | DECODE read regs, pc+imm | EXEC alu/branch/addr | MREQ dreq | MWAIT mdr | WB rd, pc | HALT stop
module mc_core
  import mc_core_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam logic [2:0] F3_MEM = (XLEN == 64) ? F3_D : F3_W;

  state_t          state_q;
  logic [31:0]     pc_q, ir_q;
  logic [XLEN-1:0] a_q, b_q, aluout_q, mdr_q;
  logic            imem_req_q, dmem_req_q, dmem_we_q, halted_q, illegal_q;
  logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [XLEN-1:0] rs1_data, rs2_data, alu_b, alu_res, mem_addr, wb_data;
  logic            legal, br_taken, wb_en;
  alu_op_t         alu_op;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  assign imm_i = XLEN'($signed(ir_q[31:20]));
  assign imm_s = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
  assign imm_b = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE && funct3 == F3_ADD) begin
          legal = 1'b1; alu_op = ALU_ADD;
        end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          legal = 1'b1; alu_op = ALU_SUB;
        end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
          legal = 1'b1; alu_op = ALU_AND;
        end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
          legal = 1'b1; alu_op = ALU_OR;
        end
      end
      OP_ADDI:           legal = (funct3 == F3_ADD);
      OP_LOAD, OP_STORE: legal = (funct3 == F3_MEM);
      OP_BRANCH:         legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      OP_JAL:            legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

  assign alu_b = (opcode == OP_RTYPE) ? b_q : imm_i;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = a_q + alu_b;
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      default: alu_res = '0;
    endcase
  end

  assign br_taken = (a_q == b_q) ^ (funct3 == F3_BNE);
  assign mem_addr = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign wb_en    = (state_q == S_WB);
  assign wb_data  = (opcode == OP_JAL)  ? XLEN'(pc_q + 32'd4) :
                    (opcode == OP_LOAD) ? mdr_q : aluout_q;

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .rst_n (reset),
    .ra1_i (ir_q[19:15]),
    .ra2_i (ir_q[24:20]),
    .rad_i (dbg_raddr),
    .we_i  (wb_en),
    .wa_i  (ir_q[11:7]),
    .wd_i  (wb_data),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data),
    .rdd_o (dbg_rdata)
  );

  // Request outputs are registered; after reset FETCH spends one cycle raising imem_req.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      aluout_q     <= '0;
      mdr_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          if (imem_rvalid) begin
            ir_q    <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q      <= rs1_data;
          b_q      <= rs2_data;
          aluout_q <= XLEN'(pc_q) + ((opcode == OP_JAL) ? imm_j : imm_b);
          if (ir_q == EBREAK_WORD) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (!legal) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_LOAD, OP_STORE: begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= (opcode == OP_STORE);
              dmem_addr_q  <= mem_addr;
              dmem_wdata_q <= b_q;
              state_q      <= S_MREQ;
            end
            OP_BRANCH: begin
              pc_q       <= br_taken ? aluout_q[31:0] : pc_q + 32'd4;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end
            OP_JAL: state_q <= S_WB;
            default: begin
              aluout_q <= alu_res;
              state_q  <= S_WB;
            end
          endcase
        end
        S_MREQ: begin
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            if (dmem_we_q) begin
              pc_q       <= pc_q + 32'd4;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              state_q <= S_MWAIT;
            end
          end
        end
        S_MWAIT: begin
          if (dmem_rvalid) begin
            mdr_q   <= dmem_rdata;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          pc_q       <= (opcode == OP_JAL) ? aluout_q[31:0] : pc_q + 32'd4;
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule
